// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Operand/result bundle for the bit-serial subtractor.
//               master : requester (drives start and operands)
//               slave  : subtractor (drives busy/done/diff/b_out[/ovf])
// Signals     : i_start, i_a[WIDTH], i_b[WIDTH], i_b_in   (master -> slave)
//               o_busy, o_done, o_diff[WIDTH], o_b_out    (slave -> master)
//               o_ovf (only when SERIAL_SUB_OVF_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_b_in;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             o_ovf;
`endif

  modport master (
`ifdef SERIAL_SUB_OVF_EN
    input  o_ovf,
`endif
    output i_start, i_a, i_b, i_b_in,
    input  o_busy, o_done, o_diff, o_b_out
  );

  modport slave (
`ifdef SERIAL_SUB_OVF_EN
    output o_ovf,
`endif
    input  i_start, i_a, i_b, i_b_in,
    output o_busy, o_done, o_diff, o_b_out
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial ripple-borrow subtractor, diff = a - b - b_in,
//               one bit per clock, LSB first. Operands are captured on an
//               accepted start; the result is published with a one-cycle
//               done pulse WIDTH+1 clocks after the accepting edge.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - serial_subtractor_if.slave (start/operands in,
//                       busy/done/diff/b_out[/ovf] out, all registered)
// Options     : SERIAL_SUB_OVF_EN - adds the signed-overflow output o_ovf
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int c_CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_br;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_br_msb;
  logic             r_ovf;
`endif

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_sr_next;

  // One-bit full subtractor on the current LSBs.
  assign w_d       = r_ra[0] ^ r_rb[0] ^ r_br;
  assign w_br_next = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);

  // Result bits enter at the MSB and drift down, so after WIDTH steps the
  // first (LSB) result bit sits at position 0. Written bitwise so WIDTH=1
  // needs no special case.
  always_comb begin
    w_sr_next            = r_sr >> 1;
    w_sr_next[WIDTH-1]   = w_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_ra     <= '0;
      r_rb     <= '0;
      r_br     <= 1'b0;
      r_sr     <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_br_msb <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.i_start) begin
            r_ra    <= bus.i_a;
            r_rb    <= bus.i_b;
            r_br    <= bus.i_b_in;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_busy  <= 1'b1;
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          r_sr  <= w_sr_next;
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            // Borrow into the sign bit; compared with the borrow out of it
            // to detect signed overflow.
`ifdef SERIAL_SUB_OVF_EN
            r_br_msb <= r_br;
`endif
            r_busy  <= 1'b0;
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_diff  <= r_sr;
          r_bout  <= r_br;
`ifdef SERIAL_SUB_OVF_EN
          r_ovf   <= r_br_msb ^ r_br;
`endif
          r_done  <= 1'b1;
          r_state <= c_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_diff  = r_diff;
  assign bus.o_b_out = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.o_ovf   = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8).
//               Directed vectors push expected results into a queue; an
//               independent monitor pops and compares on every done pulse
//               and checks hold behaviour and busy length in between.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t q[$];

  logic [W-1:0] hold_d;
  logic         hold_bo;
  logic         hold_ov;
  int           busy_run;

  serial_subtractor_if #(.WIDTH(W)) ifc ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Start pulse on the next negedge; accept happens on the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    @(negedge clk);
    ifc.i_a     = a;
    ifc.i_b     = b;
    ifc.i_b_in  = bin;
    ifc.i_start = 1'b1;
    e.d = ed; e.bo = eb; e.ov = eo; e.cyc = cyc + W + 2;
    q.push_back(e);
    @(negedge clk);
    ifc.i_start = 1'b0;
    // Scramble operands: the DUT must have captured them already.
    ifc.i_a     = ~a;
    ifc.i_b     = ~b;
    ifc.i_b_in  = ~bin;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
      end else begin
        if (ifc.o_busy) busy_run++;
        if (ifc.o_done) begin
          chk("busy_and_done", {31'd0, ifc.o_busy}, 0);
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("diff", {24'd0, ifc.o_diff}, {24'd0, e.d});
            chk("b_out", {31'd0, ifc.o_b_out}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", {31'd0, ifc.o_ovf}, {31'd0, e.ov});
`endif
            chk("done_cycle", cyc, e.cyc);
            chk("busy_cycles", busy_run, W);
            hold_d  = e.d;
            hold_bo = e.bo;
            hold_ov = e.ov;
          end
          busy_run = 0;
        end else begin
          chk("diff_hold", {24'd0, ifc.o_diff}, {24'd0, hold_d});
          chk("b_out_hold", {31'd0, ifc.o_b_out}, {31'd0, hold_bo});
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf_hold", {31'd0, ifc.o_ovf}, {31'd0, hold_ov});
`endif
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   k;
    n_tests = 0; n_fail = 0; cyc = 0;
    hold_d = '0; hold_bo = 1'b0; hold_ov = 1'b0;
    ifc.i_start = 1'b0; ifc.i_a = '0; ifc.i_b = '0; ifc.i_b_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, ifc.o_busy}, 0);
    chk("rst_done", {31'd0, ifc.o_done}, 0);
    chk("rst_diff", {24'd0, ifc.o_diff}, 0);
    chk("rst_b_out", {31'd0, ifc.o_b_out}, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {31'd0, ifc.o_ovf}, 0);
`endif
    rst_n = 1'b1;

    // Directed vectors: a, b, b_in -> diff, b_out, ovf
    issue(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0); drain();
    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0); drain();
    issue(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0); drain();
    issue(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0); drain();
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1); drain();
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1); drain();
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0); drain();

    // start re-pulsed at cycle 3 of an operation is ignored.
    issue(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    ifc.i_a = 8'hFF; ifc.i_b = 8'h01; ifc.i_b_in = 1'b0; ifc.i_start = 1'b1;
    @(negedge clk);
    ifc.i_start = 1'b0;
    drain();
    repeat (W + 4) @(negedge clk);  // a wrongly queued op would surface here

    // start held high: back-to-back operations every W+2 clocks.
    @(negedge clk);
    k = cyc;
    ifc.i_a = 8'hC8; ifc.i_b = 8'h64; ifc.i_b_in = 1'b0; ifc.i_start = 1'b1;
    e.d = 8'h64; e.bo = 1'b0; e.ov = 1'b1; e.cyc = k + W + 2;      // -56-100 overflows
    q.push_back(e);
    @(negedge clk);
    ifc.i_a = 8'h05; ifc.i_b = 8'h09; ifc.i_b_in = 1'b1;
    e.d = 8'hFB; e.bo = 1'b1; e.ov = 1'b0; e.cyc = k + 2 * W + 4;
    q.push_back(e);
    repeat (W + 2) @(negedge clk);
    ifc.i_start = 1'b0;
    drain();

    // Reset mid-operation: outputs clear at once, no done pulse.
    issue(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, ifc.o_busy}, 0);
    chk("abort_done", {31'd0, ifc.o_done}, 0);
    chk("abort_diff", {24'd0, ifc.o_diff}, 0);
    chk("abort_b_out", {31'd0, ifc.o_b_out}, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", {31'd0, ifc.o_ovf}, 0);
`endif
    q.delete();
    hold_d = '0; hold_bo = 1'b0; hold_ov = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);  // any done here is unexpected
    issue(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0); drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
